// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue stage:
//   - ALU opcode constants (4-bit) understood by the downstream execute ALU
//   - default datapath / register-index widths
//   - issue_entry_t: one decoded op as held in the issue queue
//   - snoop_entry(): applies a regfile writeback to an entry's stored
//     source data so queued ops never keep stale register values
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_REGW = 5;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;  // sub / slt
  localparam logic [3:0] ALU_SLL = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SRA = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_AND = 4'd7;

  typedef struct packed {
    logic [3:0]          aluop;
    logic [DEF_REGW-1:0] rd;
    logic [DEF_REGW-1:0] rs1;
    logic [DEF_REGW-1:0] rs2;
    logic [DEF_XLEN-1:0] rs1_data;
    logic [DEF_XLEN-1:0] rs2_data;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] imm;
    logic                src1_pc;
    logic                src2_imm;
  } issue_entry_t;

  // Register x0 is never written, so a writeback to index 0 is ignored.
  function automatic issue_entry_t snoop_entry(
    input issue_entry_t        e,
    input logic                wb_en,
    input logic [DEF_REGW-1:0] wb_rd,
    input logic [DEF_XLEN-1:0] wb_data
  );
    issue_entry_t r;
    r = e;
    if (wb_en && (wb_rd != '0)) begin
      if (e.rs1 == wb_rd) r.rs1_data = wb_data;
      if (e.rs2 == wb_rd) r.rs2_data = wb_data;
    end
    return r;
  endfunction

endpackage

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
// Small FIFO of decoded ALU ops with writeback snooping on every stored
// entry (and on the entry being written this cycle).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empties the queue (pointers and count to zero)
//   push/push_entry write an entry at the tail (caller gates with ready)
//   pop             advance the head (caller gates with !empty)
//   head            entry at the head of the queue
//   empty, ready    count==0, count<DEPTH (registered count only)
//   wb_en/wb_rd/wb_data  regfile writeback being snooped
// ---------------------------------------------------------------------------
module issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  issue_entry_t        push_entry,
  input  logic                pop,
  output issue_entry_t        head,
  output logic                empty,
  output logic                ready,
  input  logic                wb_en,
  input  logic [DEF_REGW-1:0] wb_rd,
  input  logic [DEF_XLEN-1:0] wb_data
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = PTRW + 1;

  issue_entry_t    entry_reg [DEPTH];
  logic [PTRW-1:0] wr_ptr_reg;
  logic [PTRW-1:0] rd_ptr_reg;
  logic [CNTW-1:0] count_reg;

  // Storage carries no reset: count/pointers alone define what is valid.
  // Each slot either takes the new entry or re-snoops its own contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_ptr_reg == PTRW'(i))) begin
        entry_reg[i] <= snoop_entry(push_entry, wb_en, wb_rd, wb_data);
      end else begin
        entry_reg[i] <= snoop_entry(entry_reg[i], wb_en, wb_rd, wb_data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNTW'(push) - CNTW'(pop);
    end
  end

  assign head  = entry_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign ready = (count_reg < CNTW'(DEPTH));

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
// Issue stage in front of the execute ALU. Queues decoded ops, resolves
// operands (x0, ALU-result bypass, writeback forward, stored regfile data,
// pc/imm select), stalls the head one cycle on a back-to-back RAW hazard,
// and drives registered aluop/aluin1/aluin2 into the ALU.
// Ports:
//   clk, rst, flush                  clock, sync reset, pipeline flush
//   in_valid/in_ready + in_*         decoded op handshake and fields
//   alu_result                       ALU output (result of op issued last edge)
//   wb_en/wb_rd/wb_data              regfile writeback
//   aluop/aluin1/aluin2              registered op and operands to the ALU
//   ex_valid/ex_rd                   op in the ex registers is real / its dest
//   res_valid/res_rd                 alu_result is real / its dest
// ---------------------------------------------------------------------------
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = DEF_XLEN,
  parameter int REGW  = DEF_REGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_aluop,
  input  logic [REGW-1:0] in_rd,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_src1_pc,
  input  logic            in_src2_imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            wb_en,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [3:0]      aluop,
  output logic [XLEN-1:0] aluin1,
  output logic [XLEN-1:0] aluin2,
  output logic            ex_valid,
  output logic [REGW-1:0] ex_rd,
  output logic            res_valid,
  output logic [REGW-1:0] res_rd
);

  issue_entry_t push_entry;
  issue_entry_t head;
  logic         q_empty;
  logic         q_ready;
  logic         push;
  logic         hazard;
  logic         issue;
  logic [XLEN-1:0] op1_next;
  logic [XLEN-1:0] op2_next;

  logic [3:0]      aluop_reg;
  logic [XLEN-1:0] aluin1_reg;
  logic [XLEN-1:0] aluin2_reg;
  logic            ex_valid_reg;
  logic [REGW-1:0] ex_rd_reg;
  logic            res_valid_reg;
  logic [REGW-1:0] res_rd_reg;

  always_comb begin
    push_entry          = '0;
    push_entry.aluop    = in_aluop;
    push_entry.rd       = in_rd;
    push_entry.rs1      = in_rs1;
    push_entry.rs2      = in_rs2;
    push_entry.rs1_data = in_rs1_data;
    push_entry.rs2_data = in_rs2_data;
    push_entry.pc       = in_pc;
    push_entry.imm      = in_imm;
    push_entry.src1_pc  = in_src1_pc;
    push_entry.src2_imm = in_src2_imm;
  end

  // A flush drops any op offered in the same cycle.
  assign push     = in_valid && q_ready && !flush;
  assign in_ready = q_ready;

  issue_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (issue),
    .head       (head),
    .empty      (q_empty),
    .ready      (q_ready),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  // The op in ex produces its result only next cycle, so a consumer at the
  // head waits exactly one cycle and then picks it up via the alu_result
  // bypass. Operands replaced by pc/imm are not real dependencies.
  always_comb begin
    hazard = 1'b0;
    if (ex_valid_reg && (ex_rd_reg != '0)) begin
      if (!head.src1_pc  && (head.rs1 == ex_rd_reg)) hazard = 1'b1;
      if (!head.src2_imm && (head.rs2 == ex_rd_reg)) hazard = 1'b1;
    end
  end

  assign issue = !q_empty && !hazard && !flush;

  // Youngest value wins: in-flight ALU result, then this cycle's writeback,
  // then the (already snooped) data stored with the entry.
  always_comb begin
    op1_next = '0;
    if (head.src1_pc)                                  op1_next = head.pc;
    else if (head.rs1 == '0)                           op1_next = '0;
    else if (res_valid_reg && (res_rd_reg == head.rs1)) op1_next = alu_result;
    else if (wb_en && (wb_rd == head.rs1))             op1_next = wb_data;
    else                                               op1_next = head.rs1_data;
  end

  always_comb begin
    op2_next = '0;
    if (head.src2_imm)                                 op2_next = head.imm;
    else if (head.rs2 == '0)                           op2_next = '0;
    else if (res_valid_reg && (res_rd_reg == head.rs2)) op2_next = alu_result;
    else if (wb_en && (wb_rd == head.rs2))             op2_next = wb_data;
    else                                               op2_next = head.rs2_data;
  end

  // Ex data registers only load on issue; on bubbles and flushes they hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      aluop_reg     <= '0;
      aluin1_reg    <= '0;
      aluin2_reg    <= '0;
      ex_valid_reg  <= 1'b0;
      ex_rd_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_rd_reg    <= '0;
    end else begin
      res_valid_reg <= ex_valid_reg && !flush;
      res_rd_reg    <= ex_rd_reg;
      ex_valid_reg  <= issue;
      if (issue) begin
        aluop_reg  <= head.aluop;
        ex_rd_reg  <= head.rd;
        aluin1_reg <= op1_next;
        aluin2_reg <= op2_next;
      end
    end
  end

  assign aluop     = aluop_reg;
  assign aluin1    = aluin1_reg;
  assign aluin2    = aluin2_reg;
  assign ex_valid  = ex_valid_reg;
  assign ex_rd     = ex_rd_reg;
  assign res_valid = res_valid_reg;
  assign res_rd    = res_rd_reg;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Issue stage directly upstream of the execute ALU; the ALU registers aluout on every clk edge.
- Buffers decoded ALU ops in a small queue and resolves operands: regfile data, pc/imm select, writeback snoop, and bypass from the ALU result.
- Inserts a one-cycle bubble on a back-to-back RAW dependency, then drives registered aluop/aluin1/aluin2 into the ALU.

Parameters:
DEPTH, 2, queue entries (power of 2, >=2)
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill all queued and issued-not-completed ops
in_valid  in  1  decoded op valid
in_ready  out  1  queue can accept
in_aluop  in  4  ALU op (0 add,1 sub/slt,2 sll,3 xor,4 srl,5 sra,6 or,7 and)
in_rd / in_rs1 / in_rs2  in  REGW each  dest/source indices
in_rs1_data / in_rs2_data  in  XLEN each  regfile read data
in_pc / in_imm  in  XLEN each  pc and immediate/shamt
in_src1_pc  in  1  operand1 = pc instead of rs1
in_src2_imm  in  1  operand2 = imm instead of rs2
alu_result  in  XLEN  ALU aluout
wb_en  in  1  regfile write enable
wb_rd  in  REGW  write index
wb_data  in  XLEN  write data
aluop  out  4  registered op to ALU
aluin1 / aluin2  out  XLEN each  registered operands to ALU
ex_valid  out  1  aluop/aluin hold a real op this cycle
ex_rd  out  REGW  dest of op in ex regs
res_valid  out  1  alu_result valid this cycle (ex_valid delayed 1)
res_rd  out  REGW  dest of alu_result

Behaviour:
- Reset (rst=1 at edge): queue empty; ex_valid=0, aluop=0, aluin1=0, aluin2=0, ex_rd=0, res_valid=0, res_rd=0. in_ready=1 after reset.
- in_ready = (count<DEPTH), from registered count only; no pass-through when full.
- Enqueue on in_valid&in_ready edge; an op enqueued at edge T issues no earlier than edge T+1.
- ALU result of an op issued at edge E appears on alu_result during cycle E+1 (res_valid=1).
- System contract: writeback presents that result on wb port during cycle E+2.
- Snoop: every cycle, if wb_en and wb_rd!=0, the stored rs1_data/rs2_data of each matching queued entry is overwritten with wb_data. This includes the entry being enqueued that same cycle.
- Hazard: the head stalls when ex_valid & ex_rd!=0 and ex_rd matches a used source.
  - A source is used when: rs1 with !src1_pc; rs2 with !src2_imm.
  - Result: exactly one bubble for a dependent back-to-back op.
- Issue: at each edge where the queue is non-empty, there is no hazard, and flush=0, pop the head and load the ex regs.
  - aluop = head op; ex_rd = head rd; ex_valid = 1.
  - Operand1 = pc if src1_pc, else rs1 resolved. Operand2 = imm if src2_imm, else rs2 resolved.
  - Resolution priority: index 0 → 0; res_valid & res_rd==idx → alu_result; wb_en & wb_rd==idx → wb_data; else stored data.
- No issue at an edge: ex_valid=0; aluop/aluin/ex_rd hold their values.
- res_valid and res_rd <= ex_valid and ex_rd every edge.
- Simultaneous enqueue+issue: count unchanged; FIFO order preserved.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- flush=1 at an edge (rst has priority over flush):
  - count=0, pointers=0, ex_valid=0, res_valid=0.
  - Any same-cycle enqueue is dropped.
  - ex data regs hold.
- A mid-operation rst behaves identically to power-on reset.
- Widths: all operands are XLEN. No arithmetic is done here beyond index compares.

Decomposition:
- Package alu_pkg: ALU_ADD..ALU_AND opcode constants (4-bit), XLEN/REGW defaults, issue-entry struct {aluop, rd, rs1, rs2, rs1_data, rs2_data, pc, imm, src1_pc, src2_imm}.
- Sub-module issue_queue: entry storage, pointers, count, wb snoop. alu_issue_stage holds the hazard check, operand resolution and ex/res registers.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → in_ready=1, ex_valid=0, aluin1=aluin2=0, res_valid=0, no enqueue.
- Single op: add rd=3, rs1_data=5, rs2_data=7 accepted at edge T → at T+1 ex_valid=1, aluop=0, aluin1=5, aluin2=7, ex_rd=3 → at T+2 res_valid=1, res_rd=3.
- Dependency: add rd=3 (5+7) then sub rs1=3, rs2_data=2 on consecutive cycles → one cycle ex_valid=0, then sub issues with aluin1=12 (from alu_result), aluin2=2, aluop=1.
- Full: stall the head via hazard and offer 3 ops → in_ready=0 after 2 accepted, third held until a pop. Issue order matches input order.
- Snoop/x0: queued entry with rs2=4, data 0 while wb_en=1, wb_rd=4, wb_data=0x55 → issues aluin2=0x55. Entry with rs1=0 while wb_rd=0, wb_data=9 → aluin1=0. src1_pc=1 with pc=0x100 → aluin1=0x100.
- Flush: 2 ops queued plus one in ex, flush=1 with in_valid=1 → next cycle count=0, in_ready=1, ex_valid=0, res_valid=0, new op dropped.
